// File: rtl/carry_select_pkg.sv
// carry_select_pkg: shared widths and types for the carry-select adder
package carry_select_pkg;
  localparam int WIDTH = 32;
  localparam int BLOCK = 4;
  localparam int NBLK = WIDTH / BLOCK;
  typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/carry_select_rca.sv
// rca_block: BLOCK-bit ripple-carry adder used for every carry-select slice
module rca_block
  import carry_select_pkg::*;
#(
  parameter int W = BLOCK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);
  logic c;
  always_comb begin
    c = ci;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

// File: rtl/carry_select.sv
// carry_select: registered carry-select adder {cout,s} = a + b + cin, one cycle latency.
// Define CARRY_SELECT_OVF_EN to add a registered two's-complement overflow flag ovf.
module carry_select
  import carry_select_pkg::*;
#(
  parameter int WIDTH = carry_select_pkg::WIDTH,
  parameter int BLOCK = carry_select_pkg::BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CARRY_SELECT_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NB = WIDTH / BLOCK;
  logic [WIDTH-1:0] sum;
  logic [NB:0] c;
  assign c[0] = cin;
  for (genvar g = 0; g < NB; g++) begin : g_slice
    if (g == 0) begin : g_ripple
      rca_block #(.W(BLOCK)) u_rca (
        .a(a[BLOCK-1:0]), .b(b[BLOCK-1:0]), .ci(cin), .sum(sum[BLOCK-1:0]), .co(c[1])
      );
    end else begin : g_select
      logic [BLOCK-1:0] sum0, sum1;
      logic c0, c1;
      rca_block #(.W(BLOCK)) u_rca0 (
        .a(a[g*BLOCK +: BLOCK]), .b(b[g*BLOCK +: BLOCK]), .ci(1'b0), .sum(sum0), .co(c0)
      );
      rca_block #(.W(BLOCK)) u_rca1 (
        .a(a[g*BLOCK +: BLOCK]), .b(b[g*BLOCK +: BLOCK]), .ci(1'b1), .sum(sum1), .co(c1)
      );
      // the previous slice's selected carry is the only thing on the critical chain
      assign sum[g*BLOCK +: BLOCK] = c[g] ? sum1 : sum0;
      assign c[g+1] = c[g] ? c1 : c0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
      cout <= 1'b0;
    end else begin
      s <= sum;
      cout <= c[NB];
    end
  end
`ifdef CARRY_SELECT_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else ovf <= (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end
`endif
endmodule

// File: tb/tb_carry_select.sv
// tb_carry_select: directed and random checks of carry_select against an arithmetic model
module tb_carry_select;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] a, b, s;
  logic cin, cout;
`ifdef CARRY_SELECT_OVF_EN
  logic ovf;
`endif
  int errors = 0;
  int checks = 0;

  carry_select dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .s(s), .cout(cout)
`ifdef CARRY_SELECT_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [31:0] x, input logic [31:0] y, input logic c, input string tag);
    logic [32:0] ref_sum;
    longint sx;
    a = x;
    b = y;
    cin = c;
    @(posedge clk);
    #1;
    ref_sum = {1'b0, x} + {1'b0, y} + {32'd0, c};
    chk({tag, "_s"}, {32'd0, s}, {32'd0, ref_sum[31:0]});
    chk({tag, "_cout"}, {63'd0, cout}, {63'd0, ref_sum[32]});
    sx = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
`ifdef CARRY_SELECT_OVF_EN
    chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, (sx > 64'sd2147483647) || (sx < -64'sd2147483648)});
`endif
  endtask

  initial begin
    rst = 1'b1;
    a = 32'hFFFF_FFFF;
    b = 32'd1;
    cin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_s", {32'd0, s}, 64'd0);
      chk("rst_cout", {63'd0, cout}, 64'd0);
`ifdef CARRY_SELECT_OVF_EN
      chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
    end
    rst = 1'b0;
    op(32'hFFFF_FFFF, 32'd1, 1'b0, "post_rst");
    chk("post_rst_const", {31'd0, cout, s}, 64'h1_0000_0000);
    op(32'hB67A_2A3D, 32'hF0F0_F0F0, 1'b0, "primary");
    chk("primary_const", {31'd0, cout, s}, 64'h1_A76B_1B2D);
    op(32'hFFFF_FFFF, 32'd0, 1'b1, "cin_all");
    chk("cin_all_const", {31'd0, cout, s}, 64'h1_0000_0000);
    op(32'h0000_000F, 32'd0, 1'b1, "cin_slice0");
    chk("cin_slice0_const", {31'd0, cout, s}, 64'h0_0000_0010);
    op(32'd0, 32'd0, 1'b0, "zero");
    op(32'h1234_5678, 32'h8765_4321, 1'b1, "ident");
    chk("ident_const", {31'd0, cout, s}, 64'h0_9999_999A);
    op(32'h1234_5678, 32'h8765_4321, 1'b1, "hold");
    op(32'h7FFF_FFFF, 32'd1, 1'b0, "ovf_pos");
    op(32'h8000_0000, 32'h8000_0000, 1'b0, "ovf_neg");
    op(32'h7FFF_FFFF, 32'd0, 1'b1, "ovf_cin");
    // reset mid-stream with live inputs must clear outputs, then resume without stale data
    rst = 1'b1;
    a = 32'hDEAD_BEEF;
    b = 32'hCAFE_F00D;
    cin = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst", {31'd0, cout, s}, 64'd0);
    rst = 1'b0;
    op(32'h0000_0003, 32'h0000_0004, 1'b0, "after_rst");
    for (int i = 0; i < 10000; i++)
      op($urandom, $urandom, 1'($urandom_range(0, 1)), "rand");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/carry_select.md
Name: carry_select

Overview:
- Registered WIDTH-bit carry-select adder. Default 32 bits, s = a + b + cin, with carry-out.
- Operand is split into BLOCK-bit slices. Each slice above slice 0 computes two sums in parallel (carry-in 0 and carry-in 1), and the real incoming carry muxes the result.
- Used as the fast adder in the processor datapath/ALU. Result is captured in an output register, so the block is one pipeline stage.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of BLOCK.
- BLOCK, 4, bits per carry-select slice; NBLK = WIDTH/BLOCK.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- s  output  WIDTH  registered sum, a+b+cin mod 2^WIDTH.
- cout  output  1  registered carry-out of bit WIDTH-1.

Interface note (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset: on a rising clk with rst=1, s<=0 and cout<=0 (plus ovf<=0 when the optional feature is enabled). rst overrides any inputs on that edge.
- Latency: exactly 1 cycle. Inputs present before rising edge N appear on s/cout after edge N. No handshake; a new operation is accepted every cycle.
- Slice 0 (bits BLOCK-1:0): plain ripple-carry add using cin directly.
- Slice k>0 has two ripple-carry adders on the same a/b slice:
  - one with carry-in 0, giving (sum0, c0);
  - one with carry-in 1, giving (sum1, c1).
  - The carry out of slice k-1 selects: slice sum = sel ? sum1 : sum0; slice carry = sel ? c1 : c0.
- cout = selected carry of slice NBLK-1.
- Arithmetic: {cout,s} == a + b + cin as an exact (WIDTH+1)-bit unsigned sum for all inputs.
  - Wrap-around: all-ones + 1 gives s=0, cout=1.
- The combinational path is the sum-selection chain of NBLK muxes, not a WIDTH-bit ripple.
- Holding inputs constant keeps outputs constant. No internal state other than the output registers.
- rst asserted mid-stream: outputs clear on that edge. The first valid result follows 1 cycle after rst drops, with no stale value.

Optional Feature:
- Macro CARRY_SELECT_OVF_EN.
- When defined: adds port ovf (output, 1 bit), a registered two's-complement overflow flag.
  - ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), computed from the pre-register sum.
  - Reset value 0; same 1-cycle latency as s.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package carry_select_pkg:
  - default WIDTH/BLOCK constants;
  - derived NBLK;
  - width typedef word_t (logic [WIDTH-1:0]).
- One natural sub-module: rca_block, a BLOCK-bit ripple-carry adder (a, b, ci -> sum, co). Instantiated once for slice 0 and twice per upper slice via generate.
- Muxes and output register stay in carry_select.

Test Plan:
- Reset: rst=1 for 2 cycles with a=0xFFFFFFFF, b=1 -> s=0, cout=0 while reset; after release, the next cycle gives s=0, cout=1.
- Primary vector: a=0xB67A2A3D, b=0xF0F0F0F0, cin=0 -> one cycle later s=0xA76B1B2D, cout=1 (ovf=0 if enabled).
- Carry-in propagation across all slices: a=0xFFFFFFFF, b=0, cin=1 -> s=0x00000000, cout=1. Also a=0x0000000F, b=0, cin=1 -> s=0x00000010, cout=0.
- Zero/identity: a=0, b=0, cin=0 -> s=0, cout=0. Also a=0x12345678, b=0x87654321, cin=1 -> s=0x9999999A, cout=0.
- Overflow (with CARRY_SELECT_OVF_EN): a=0x7FFFFFFF, b=1, cin=0 -> s=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 -> s=0, cout=1, ovf=1.
- Back-to-back/random: new random a/b/cin every cycle for 10k cycles -> each output equals the reference {cout,s}=a+b+cin of the previous cycle's inputs.
